// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types and flat-image indexing for the matrix transport path
package matrix_pkg;

  // Receive-side FSM: gathering beats, or holding a complete matrix.
  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  // Number of beats that carry one full matrix.
  function automatic int num_beats(input int width, input int height, input int beat_elems);
    return (width * height) / beat_elems;
  endfunction

  // Row-major flat index convention, common to flattener and unflattener:
  // element e lives at A[e / width][e % width].
  function automatic int flat_index(input int row, input int col, input int width);
    return row * width + col;
  endfunction

  function automatic int flat_row(input int e, input int width);
    return e / width;
  endfunction

  function automatic int flat_col(input int e, input int width);
    return e % width;
  endfunction

endpackage

// File: rtl/matrix_unflattener_if.sv
// rtl/matrix_unflattener_if.sv - beat input stream and held matrix output bundle
interface matrix_unflattener_if #(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 4,
  parameter int P          = 8,
  parameter int BEAT_ELEMS = 8
);

  logic [BEAT_ELEMS*P-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_last;
  logic signed [P-1:0]     A [HEIGHT][WIDTH];
  logic                    out_valid;
  logic                    out_ready;
  logic                    err;

  // Producer of beats and consumer of matrices.
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, A, out_valid, err
  );

  // The unflattener itself.
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, A, out_valid, err
  );

endinterface

// File: rtl/matrix_unflattener.sv
// rtl/matrix_unflattener.sv - beat-stream to held matrix deserializer (optional MATRIX_UNFLATTENER_LAST_CHECK_EN framing check)
module matrix_unflattener
  import matrix_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 4,
  parameter int P          = 8,
  parameter int BEAT_ELEMS = 8
) (
  input logic                clk,
  input logic                rst_n,
  matrix_unflattener_if.slave bus
);

  localparam int NUM_BEATS = num_beats(WIDTH, HEIGHT, BEAT_ELEMS);
  localparam int CW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_BEATS - 1);

  if ((WIDTH * HEIGHT) % BEAT_ELEMS != 0) begin : g_bad_beat_elems
    $error("BEAT_ELEMS must divide WIDTH*HEIGHT exactly");
  end

  state_e              state, state_n;
  logic [CW-1:0]       beat_cnt, cnt_n;
  logic                wr_en;
  logic signed [P-1:0] mat [HEIGHT][WIDTH];

`ifdef MATRIX_UNFLATTENER_LAST_CHECK_EN
  logic err_q, err_n;
`else
  logic unused_last;
  assign unused_last = bus.in_last;
`endif

  // Handshake outputs come straight from the state register, so out_ready
  // never reaches in_ready combinationally.
  assign bus.in_ready  = (state == COLLECT);
  assign bus.out_valid = (state == FULL);
  assign bus.A         = mat;

  // State and beat counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= COLLECT;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      beat_cnt <= cnt_n;
    end
  end

  // Next-state, counter advance and framing-error decisions.
  always_comb begin
    state_n = state;
    cnt_n   = beat_cnt;
    wr_en   = 1'b0;
`ifdef MATRIX_UNFLATTENER_LAST_CHECK_EN
    err_n   = err_q;
`endif
    case (state)
      COLLECT: begin
        if (bus.in_valid) begin
          wr_en = 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            cnt_n   = '0;
            state_n = FULL;
`ifdef MATRIX_UNFLATTENER_LAST_CHECK_EN
            // Missing in_last is flagged, but the matrix still completes.
            if (!bus.in_last) err_n = 1'b1;
`endif
          end else begin
`ifdef MATRIX_UNFLATTENER_LAST_CHECK_EN
            // Early in_last: flag it and restart framing at beat 0.
            if (bus.in_last) begin
              err_n = 1'b1;
              cnt_n = '0;
            end else begin
              cnt_n = beat_cnt + CW'(1);
            end
`else
            cnt_n = beat_cnt + CW'(1);
`endif
          end
        end
      end
      FULL: begin
        if (bus.out_ready) state_n = COLLECT;
      end
      default: state_n = COLLECT;
    endcase
  end

  // Matrix register: each element is owned by exactly one beat slot, so an
  // accepted beat overwrites only its own BEAT_ELEMS elements.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < HEIGHT; r++) begin
        for (int c = 0; c < WIDTH; c++) begin
          mat[r][c] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int r = 0; r < HEIGHT; r++) begin
        for (int c = 0; c < WIDTH; c++) begin
          if (beat_cnt == CW'(flat_index(r, c, WIDTH) / BEAT_ELEMS)) begin
            mat[r][c] <= bus.in_data[(BEAT_ELEMS - (flat_index(r, c, WIDTH) % BEAT_ELEMS))*P-1 -: P];
          end
        end
      end
    end
  end

`ifdef MATRIX_UNFLATTENER_LAST_CHECK_EN
  // Sticky framing error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_n;
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
